// File: rtl/exu_lsu_mem_arb.sv
// Two-requester load/store arbiter onto one data-memory port with in-order response routing.
// Optional: define LSU_ARB_RR_EN for round-robin; otherwise r0 has fixed priority over r1.
//
// state | meaning
// IDLE  | pick a winner each cycle; zero-wait grant if the bus accepts immediately
// HOLD  | bus stalled; keep presenting the latched owner until mem_gnt_i
module exu_lsu_mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MAX_OS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          r0_req_i,
    input  logic                          r0_we_i,
    input  logic [ADDR_W-1:0]             r0_addr_i,
    input  logic [DATA_W-1:0]             r0_wdata_i,
    input  logic [DATA_W/8-1:0]           r0_wmask_i,
    output logic                          r0_gnt_o,
    output logic                          r0_rvalid_o,
    output logic [DATA_W-1:0]             r0_rdata_o,
    input  logic                          r1_req_i,
    input  logic                          r1_we_i,
    input  logic [ADDR_W-1:0]             r1_addr_i,
    input  logic [DATA_W-1:0]             r1_wdata_i,
    input  logic [DATA_W/8-1:0]           r1_wmask_i,
    output logic                          r1_gnt_o,
    output logic                          r1_rvalid_o,
    output logic [DATA_W-1:0]             r1_rdata_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    output logic [DATA_W/8-1:0]           mem_wmask_o,
    input  logic                          mem_gnt_i,
    input  logic                          mem_rvalid_i,
    input  logic [DATA_W-1:0]             mem_rdata_i,
    output logic [$clog2(MAX_OS+1)-1:0]   os_cnt_o,
    output logic                          err_o
);
    localparam int CNT_W = $clog2(MAX_OS + 1);
    localparam int PTR_W = (MAX_OS > 1) ? $clog2(MAX_OS) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state_q, state_d;
    logic               hold_id_q, hold_id_d;
    logic [MAX_OS-1:0]  own_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic               full, empty, push, pop, head_id;
    logic               sel_id, win_id, mem_req;

    assign full    = (cnt_q == CNT_W'(MAX_OS));
    assign empty   = (cnt_q == '0);
    assign head_id = own_q[rd_ptr_q];
    assign pop     = mem_rvalid_i & ~empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef LSU_ARB_RR_EN
    logic pref_q;

    always_comb begin
        if (r0_req_i && r1_req_i) win_id = pref_q;
        else                      win_id = ~r0_req_i;
    end

    always_ff @(posedge clk) begin
        if (rst)       pref_q <= 1'b0;
        else if (push) pref_q <= ~sel_id;
    end
`else
    assign win_id = ~r0_req_i;
`endif

    always_comb begin
        state_d   = state_q;
        hold_id_d = hold_id_q;
        mem_req   = 1'b0;
        sel_id    = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                // a pop in this same cycle does not reopen the port
                if (!full && (r0_req_i || r1_req_i)) begin
                    mem_req = 1'b1;
                    sel_id  = win_id;
                    if (mem_gnt_i) begin
                        push = 1'b1;
                    end else begin
                        state_d   = HOLD;
                        hold_id_d = win_id;
                    end
                end
            end
            HOLD: begin
                mem_req = 1'b1;
                sel_id  = hold_id_q;
                if (mem_gnt_i) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_id_q <= hold_id_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            own_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                own_q[wr_ptr_q] <= sel_id;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (mem_rvalid_i && empty) err_q <= 1'b1;
        end
    end

    assign mem_req_o   = mem_req;
    assign mem_we_o    = mem_req & (sel_id ? r1_we_i : r0_we_i);
    assign mem_addr_o  = mem_req ? (sel_id ? r1_addr_i  : r0_addr_i)  : '0;
    assign mem_wdata_o = mem_req ? (sel_id ? r1_wdata_i : r0_wdata_i) : '0;
    assign mem_wmask_o = mem_req ? (sel_id ? r1_wmask_i : r0_wmask_i) : '0;

    assign r0_gnt_o    = push & ~sel_id;
    assign r1_gnt_o    = push &  sel_id;
    assign r0_rvalid_o = pop & ~head_id;
    assign r1_rvalid_o = pop &  head_id;
    assign r0_rdata_o  = r0_rvalid_o ? mem_rdata_i : '0;
    assign r1_rdata_o  = r1_rvalid_o ? mem_rdata_i : '0;

    assign os_cnt_o = cnt_q;
    assign err_o    = err_q;
endmodule
